cva6_cfg_reader: RTL and testbench

- Read-only, memory-mapped responder that exposes the elaborated `config_pkg::cva6_cfg_t` to software and debug tools.
- The config package is the writer of the core configuration; this block is its run-time reader.
- Sits on a peripheral req/gnt + rvalid/rready port next to the debug module, so boot firmware and OpenOCD scripts can discover ISA, TLB, cache, PMP and region settings without rebuilding.

---
 rtl/config_pkg.sv | 65 ++++++
 rtl/cva6_cfg_reader_pkg.sv | 43 ++++
 rtl/fifo_v3.sv | 51 +++++
 rtl/cva6_cfg_reader.sv | 118 +++++++++++
 tb/tb_cva6_cfg_reader.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/config_pkg.sv
// config_pkg: core configuration record and the default configuration exposed by the reader.
package config_pkg;

    typedef struct packed {
        bit            RVA;
        bit            RVB;
        bit            RVC;
        bit            FpuEn;
        bit            RVH;
        bit            RVV;
        bit            RVZCB;
        bit            CvxifEn;
        bit            ZiCondExtEn;
        bit            GTlbPresent;
        bit            L2TlbPresent;
        bit            L2Tlb4KPresent;
        bit            L2Tlb2MPresent;
        bit            DebugEn;
        bit            TvalEn;
        bit            RVS;
        bit            RVU;
        int unsigned   NrCommitPorts;
        int unsigned   NrLoadBufEntries;
        int unsigned   RASDepth;
        int unsigned   BTBEntries;
        int unsigned   BHTEntries;
        int unsigned   NrPMPEntries;
        int unsigned   AxiIdWidth;
        int unsigned   AxiAddrWidth;
        int unsigned   AxiDataWidth;
        int unsigned   MaxOutstandingStores;
        logic [63:0]   HaltAddress;
        logic [63:0]   ExceptionAddress;
        logic [63:0]   DmBaseAddress;
        int unsigned   NrNonIdempotentRules;
        int unsigned   NrExecuteRegionRules;
        int unsigned   NrCachedRegionRules;
        logic [1023:0] NonIdempotentAddrBase;
        logic [1023:0] NonIdempotentLength;
        logic [1023:0] ExecuteRegionAddrBase;
        logic [1023:0] ExecuteRegionLength;
        logic [1023:0] CachedRegionAddrBase;
        logic [1023:0] CachedRegionLength;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{
        RVA: 1'b1, RVB: 1'b0, RVC: 1'b1, FpuEn: 1'b1, RVH: 1'b0, RVV: 1'b0,
        RVZCB: 1'b1, CvxifEn: 1'b0, ZiCondExtEn: 1'b1, GTlbPresent: 1'b0,
        L2TlbPresent: 1'b0, L2Tlb4KPresent: 1'b0, L2Tlb2MPresent: 1'b0,
        DebugEn: 1'b1, TvalEn: 1'b1, RVS: 1'b1, RVU: 1'b1,
        NrCommitPorts: 2, NrLoadBufEntries: 2, RASDepth: 0,
        BTBEntries: 32'h2002, BHTEntries: 32'h8000,
        NrPMPEntries: 8, AxiIdWidth: 4, AxiAddrWidth: 64, AxiDataWidth: 64,
        MaxOutstandingStores: 7,
        HaltAddress: 64'h800, ExceptionAddress: 64'h808, DmBaseAddress: 64'h0,
        NrNonIdempotentRules: 2, NrExecuteRegionRules: 3, NrCachedRegionRules: 1,
        NonIdempotentAddrBase: {896'h0, 64'h1_0000_0000, 64'h0},
        NonIdempotentLength: {896'h0, 64'h4000_0000, 64'h8000_0000},
        ExecuteRegionAddrBase: {832'h0, 64'h8000_0000, 64'h1_0000, 64'h0},
        ExecuteRegionLength: {832'h0, 64'h4000_0000, 64'h1_0000, 64'h1000},
        CachedRegionAddrBase: {960'h0, 64'h8000_0000},
        CachedRegionLength: {960'h0, 64'h4000_0000}
    };

endpackage

// File: rtl/cva6_cfg_reader_pkg.sv
// cva6_cfg_reader_pkg: register map and response type of the configuration reader.
package cva6_cfg_reader_pkg;

    localparam logic [63:0] Magic = 64'h4356_4136_4346_0001;

    // 64-bit word indices (byte offset >> 3) of the low window
    localparam logic [8:0] WordMagic  = 9'h00;
    localparam logic [8:0] WordIsa    = 9'h01;
    localparam logic [8:0] WordPipe   = 9'h02;
    localparam logic [8:0] WordMem    = 9'h03;
    localparam logic [8:0] WordHalt   = 9'h04;
    localparam logic [8:0] WordExc    = 9'h05;
    localparam logic [8:0] WordDm     = 9'h06;
    localparam logic [8:0] WordCounts = 9'h07;
    localparam logic [8:0] WordErrCnt = 9'h08;

    localparam logic [1:0] GrpExec   = 2'd1;
    localparam logic [1:0] GrpCached = 2'd2;

    localparam int unsigned IsaRva          = 0;
    localparam int unsigned IsaRvb          = 1;
    localparam int unsigned IsaRvc          = 2;
    localparam int unsigned IsaFpuEn        = 3;
    localparam int unsigned IsaRvh          = 4;
    localparam int unsigned IsaRvv          = 5;
    localparam int unsigned IsaRvzcb        = 6;
    localparam int unsigned IsaCvxifEn      = 7;
    localparam int unsigned IsaZiCondExtEn  = 8;
    localparam int unsigned IsaGTlb         = 9;
    localparam int unsigned IsaL2Tlb        = 10;
    localparam int unsigned IsaL2Tlb4K      = 11;
    localparam int unsigned IsaL2Tlb2M      = 12;
    localparam int unsigned IsaDebugEn      = 13;
    localparam int unsigned IsaTvalEn       = 14;
    localparam int unsigned IsaRvs          = 15;
    localparam int unsigned IsaRvu          = 16;

    typedef struct packed {
        logic [63:0] rdata;
        logic        rerr;
    } rsp_t;

endpackage

// File: rtl/fifo_v3.sv
// fifo_v3: synchronous FIFO; a push while full is taken when the head pops in the same cycle.
module fifo_v3 #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  full_o,
    output logic                  empty_o
);
    localparam int unsigned PtrW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]       rptr_q, rptr_d, wptr_q, wptr_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  push, pop;

    assign full_o  = cnt_q == CntW'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign pop     = pop_i & ~empty_o;
    assign push    = push_i & (~full_o | pop_i);
    assign data_o  = mem_q[rptr_q];

    always_comb begin
        wptr_d = push ? (wptr_q == PtrW'(DEPTH - 1) ? '0 : wptr_q + 1'b1) : wptr_q;
        rptr_d = pop ? (rptr_q == PtrW'(DEPTH - 1) ? '0 : rptr_q + 1'b1) : rptr_q;
        cnt_d  = cnt_q + CntW'(push) - CntW'(pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rptr_q <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            rptr_q <= rptr_d;
            wptr_q <= wptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/cva6_cfg_reader.sv
// cva6_cfg_reader: read-only MMIO window onto the elaborated CVA6 configuration,
// answering in grant order through a small response FIFO.
module cva6_cfg_reader
    import cva6_cfg_reader_pkg::*;
#(
    parameter config_pkg::cva6_cfg_t CVA6Cfg   = config_pkg::cva6_cfg_empty,
    parameter int unsigned           AddrWidth = 12,
    parameter int unsigned           RspDepth  = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_i,
    input  logic                 we_i,
    input  logic [AddrWidth-1:0] addr_i,
    output logic                 gnt_o,
    output logic                 rvalid_o,
    input  logic                 rready_i,
    output logic [63:0]          rdata_o,
    output logic                 rerr_o,
    output logic [31:0]          err_cnt_o
);
    logic [11:0]   a;
    logic [63:0]   isa, pipe, mem, counts, word, sel;
    logic [1023:0] vbase, vlen;
    logic [31:0]   nr, err_cnt_q, err_cnt_d;
    logic          hit, full, empty, pop;
    rsp_t          rsp, head;

    // the window is 4 KiB regardless of how many address bits are wired in
    assign a = 12'(addr_i);

    always_comb begin
        isa = '0;
        isa[IsaRva]         = CVA6Cfg.RVA;
        isa[IsaRvb]         = CVA6Cfg.RVB;
        isa[IsaRvc]         = CVA6Cfg.RVC;
        isa[IsaFpuEn]       = CVA6Cfg.FpuEn;
        isa[IsaRvh]         = CVA6Cfg.RVH;
        isa[IsaRvv]         = CVA6Cfg.RVV;
        isa[IsaRvzcb]       = CVA6Cfg.RVZCB;
        isa[IsaCvxifEn]     = CVA6Cfg.CvxifEn;
        isa[IsaZiCondExtEn] = CVA6Cfg.ZiCondExtEn;
        isa[IsaGTlb]        = CVA6Cfg.GTlbPresent;
        isa[IsaL2Tlb]       = CVA6Cfg.L2TlbPresent;
        isa[IsaL2Tlb4K]     = CVA6Cfg.L2Tlb4KPresent;
        isa[IsaL2Tlb2M]     = CVA6Cfg.L2Tlb2MPresent;
        isa[IsaDebugEn]     = CVA6Cfg.DebugEn;
        isa[IsaTvalEn]      = CVA6Cfg.TvalEn;
        isa[IsaRvs]         = CVA6Cfg.RVS;
        isa[IsaRvu]         = CVA6Cfg.RVU;
    end

    assign pipe = {8'h00, CVA6Cfg.BHTEntries[15:0], CVA6Cfg.BTBEntries[15:0],
                   CVA6Cfg.RASDepth[7:0], CVA6Cfg.NrLoadBufEntries[7:0], CVA6Cfg.NrCommitPorts[7:0]};
    assign mem = {CVA6Cfg.MaxOutstandingStores[15:0], CVA6Cfg.AxiDataWidth[15:0],
                  CVA6Cfg.AxiAddrWidth[15:0], CVA6Cfg.AxiIdWidth[7:0], CVA6Cfg.NrPMPEntries[7:0]};
    assign counts = {40'h0, CVA6Cfg.NrCachedRegionRules[7:0], CVA6Cfg.NrExecuteRegionRules[7:0],
                     CVA6Cfg.NrNonIdempotentRules[7:0]};

    always_comb begin
        vbase = a[9:8] == GrpExec ? CVA6Cfg.ExecuteRegionAddrBase :
                a[9:8] == GrpCached ? CVA6Cfg.CachedRegionAddrBase : CVA6Cfg.NonIdempotentAddrBase;
        vlen  = a[9:8] == GrpExec ? CVA6Cfg.ExecuteRegionLength :
                a[9:8] == GrpCached ? CVA6Cfg.CachedRegionLength : CVA6Cfg.NonIdempotentLength;
        nr    = a[9:8] == GrpExec ? CVA6Cfg.NrExecuteRegionRules :
                a[9:8] == GrpCached ? CVA6Cfg.NrCachedRegionRules : CVA6Cfg.NrNonIdempotentRules;
        sel   = a[3] ? vlen[{a[7:4], 6'd0} +: 64] : vbase[{a[7:4], 6'd0} +: 64];
        word  = '0;
        hit   = 1'b1;
        case (a[11:3])
            WordMagic:  word = Magic;
            WordIsa:    word = isa;
            WordPipe:   word = pipe;
            WordMem:    word = mem;
            WordHalt:   word = CVA6Cfg.HaltAddress;
            WordExc:    word = CVA6Cfg.ExceptionAddress;
            WordDm:     word = CVA6Cfg.DmBaseAddress;
            WordCounts: word = counts;
            WordErrCnt: word = 64'(err_cnt_q);
            default: begin
                // regions live at 0x100..0x3FF; a[3] picks length over base
                hit  = a[11:10] == 2'b00 && a[9:8] != 2'b00 && 32'(a[7:4]) < nr;
                word = sel;
            end
        endcase
        rsp.rerr  = we_i | (a[2:0] != 3'd0) | ~hit;
        rsp.rdata = rsp.rerr ? '0 : word;
    end

    assign pop      = rvalid_o & rready_i;
    assign rvalid_o = ~empty;
    assign gnt_o    = req_i & (~full | pop);
    assign rdata_o  = rvalid_o ? head.rdata : '0;
    assign rerr_o   = rvalid_o & head.rerr;

    fifo_v3 #(
        .DATA_WIDTH($bits(rsp_t)),
        .DEPTH     (RspDepth)
    ) i_rsp_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push_i (gnt_o),
        .data_i (rsp),
        .pop_i  (pop),
        .data_o (head),
        .full_o (full),
        .empty_o(empty)
    );

    assign err_cnt_d = (gnt_o & rsp.rerr & ~&err_cnt_q) ? err_cnt_q + 32'd1 : err_cnt_q;
    assign err_cnt_o = err_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) err_cnt_q <= '0;
        else         err_cnt_q <= err_cnt_d;
    end

endmodule

// File: tb/tb_cva6_cfg_reader.sv
// tb_cva6_cfg_reader: directed and randomized checks of the config reader against a
// register-map model built from the default configuration.
module tb_cva6_cfg_reader;
    import config_pkg::*;

    localparam int unsigned Depth = 2;
    localparam cva6_cfg_t   C     = cva6_cfg_empty;

    logic        clk = 1'b0, rst_n = 1'b1, req = 1'b0, we = 1'b0, rready = 1'b0;
    logic [11:0] addr = '0;
    logic        gnt, rvalid, rerr;
    logic [63:0] rdata;
    logic [31:0] err_cnt;
    int          ncmp = 0, nfail = 0;
    logic [64:0] q[$];
    logic [31:0] mcnt = '0;

    always #5 clk = ~clk;

    cva6_cfg_reader #(.CVA6Cfg(C), .AddrWidth(12), .RspDepth(Depth)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .req_i    (req),
        .we_i     (we),
        .addr_i   (addr),
        .gnt_o    (gnt),
        .rvalid_o (rvalid),
        .rready_i (rready),
        .rdata_o  (rdata),
        .rerr_o   (rerr),
        .err_cnt_o(err_cnt)
    );

    // expected {rerr, rdata} for one access, straight from the register map
    function automatic logic [64:0] model(logic w, logic [11:0] a, logic [31:0] cnt);
        logic [63:0]   v;
        logic [1023:0] vec;
        int unsigned   nr, i, grp;
        bit            f[17];
        if (w || a % 8 != 0) return {1'b1, 64'h0};
        grp = 32'(a) / 256;
        i   = (32'(a) % 256) / 16;
        if (grp == 0) begin
            f = '{C.RVA, C.RVB, C.RVC, C.FpuEn, C.RVH, C.RVV, C.RVZCB, C.CvxifEn, C.ZiCondExtEn,
                  C.GTlbPresent, C.L2TlbPresent, C.L2Tlb4KPresent, C.L2Tlb2MPresent, C.DebugEn,
                  C.TvalEn, C.RVS, C.RVU};
            case (32'(a) / 8)
                0: v = 64'h4356_4136_4346_0001;
                1: begin
                    v = 0;
                    for (int k = 0; k < 17; k++) v += 64'(f[k]) << k;
                end
                2: v = 64'(C.NrCommitPorts % 256) + (64'(C.NrLoadBufEntries % 256) << 8)
                     + (64'(C.RASDepth % 256) << 16) + (64'(C.BTBEntries % 65536) << 24)
                     + (64'(C.BHTEntries % 65536) << 40);
                3: v = 64'(C.NrPMPEntries % 256) + (64'(C.AxiIdWidth % 256) << 8)
                     + (64'(C.AxiAddrWidth % 65536) << 16) + (64'(C.AxiDataWidth % 65536) << 32)
                     + (64'(C.MaxOutstandingStores % 65536) << 48);
                4: v = C.HaltAddress;
                5: v = C.ExceptionAddress;
                6: v = C.DmBaseAddress;
                7: v = 64'(C.NrNonIdempotentRules % 256) + (64'(C.NrExecuteRegionRules % 256) << 8)
                     + (64'(C.NrCachedRegionRules % 256) << 16);
                8: v = 64'(cnt);
                default: return {1'b1, 64'h0};
            endcase
            return {1'b0, v};
        end
        if (grp > 3) return {1'b1, 64'h0};
        nr = grp == 1 ? C.NrExecuteRegionRules : grp == 2 ? C.NrCachedRegionRules : C.NrNonIdempotentRules;
        if (i >= nr) return {1'b1, 64'h0};
        if (grp == 1) vec = a % 16 >= 8 ? C.ExecuteRegionLength : C.ExecuteRegionAddrBase;
        else if (grp == 2) vec = a % 16 >= 8 ? C.CachedRegionLength : C.CachedRegionAddrBase;
        else vec = a % 16 >= 8 ? C.NonIdempotentLength : C.NonIdempotentAddrBase;
        return {1'b0, 64'(vec >> (64 * i))};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // one bus cycle: drive at negedge, check mid-cycle, advance the model at posedge
    task automatic step(input logic r, input logic w, input logic [11:0] a, input logic rr);
        logic [64:0] rsp;
        logic        g_exp, pop;
        @(negedge clk);
        req = r; we = w; addr = a; rready = rr;
        #1;
        pop   = q.size() > 0 && rr;
        g_exp = r && (q.size() < Depth || pop);
        chk("gnt", 64'(gnt), 64'(g_exp));
        chk("rvalid", 64'(rvalid), 64'(q.size() > 0));
        if (q.size() > 0) begin
            chk("rdata", rdata, q[0][63:0]);
            chk("rerr", 64'(rerr), 64'(q[0][64]));
        end
        chk("err_cnt", 64'(err_cnt), 64'(mcnt));
        rsp = model(w, a, mcnt);
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (g_exp) begin
            q.push_back(rsp);
            if (rsp[64] && mcnt != 32'hFFFF_FFFF) mcnt++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        req = 1'b0; rst_n = 1'b0;
        #1;
        chk("rst_rvalid", 64'(rvalid), 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        chk("rst_rerr", 64'(rerr), 64'd0);
        chk("rst_err_cnt", 64'(err_cnt), 64'd0);
        chk("rst_gnt", 64'(gnt), 64'd0);
        q.delete();
        mcnt = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain();
        for (int k = 0; k < Depth + 2; k++) step(1'b0, 1'b0, 12'h0, 1'b1);
    endtask

    initial begin
        do_reset();

        step(1'b1, 1'b0, 12'h000, 1'b1);
        #1;
        chk("t1_rvalid", 64'(rvalid), 64'd1);
        chk("t1_magic", rdata, 64'h4356_4136_4346_0001);
        chk("t1_rerr", 64'(rerr), 64'd0);
        drain();

        step(1'b1, 1'b0, 12'h100, 1'b1);
        #1 chk("t2_base0", rdata, 64'h0);
        step(1'b1, 1'b0, 12'h108, 1'b1);
        #1 chk("t2_len0", rdata, 64'h1000);
        step(1'b1, 1'b0, 12'h120, 1'b1);
        #1 chk("t2_base2", rdata, 64'h8000_0000);
        step(1'b1, 1'b0, 12'h130, 1'b1);
        #1;
        chk("t2_oob_rerr", 64'(rerr), 64'd1);
        chk("t2_oob_rdata", rdata, 64'h0);
        chk("t2_oob_cnt", 64'(err_cnt), 64'd1);
        drain();

        do_reset();
        step(1'b1, 1'b0, 12'h000, 1'b0);
        step(1'b1, 1'b0, 12'h008, 1'b0);
        step(1'b1, 1'b0, 12'h010, 1'b0);
        step(1'b1, 1'b0, 12'h010, 1'b1);
        drain();

        do_reset();
        step(1'b1, 1'b1, 12'h008, 1'b1);
        step(1'b1, 1'b0, 12'h00C, 1'b1);
        #1 chk("t4_cnt2", 64'(err_cnt), 64'd2);
        step(1'b1, 1'b0, 12'h040, 1'b1);
        #1;
        chk("t4_errcnt_word", rdata, 64'd2);
        chk("t4_cnt_hold", 64'(err_cnt), 64'd2);
        drain();

        @(negedge clk);
        force dut.err_cnt_q = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.err_cnt_q;
        mcnt = 32'hFFFF_FFFE;
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 12'h018, 1'b1);
        #1 chk("t5_saturate", 64'(err_cnt), 64'hFFFF_FFFF);
        drain();

        step(1'b1, 1'b0, 12'h000, 1'b0);
        step(1'b1, 1'b0, 12'h038, 1'b0);
        do_reset();
        step(1'b1, 1'b0, 12'h010, 1'b1);
        #1 chk("t6_pipe", rdata, 64'h0080_0020_0200_0202);
        drain();

        for (int n = 0; n < 500; n++) begin
            logic [11:0] ra;
            ra = 12'($urandom);
            if ($urandom % 4 != 0) ra[2:0] = 3'd0;
            if ($urandom % 2 != 0) ra[11:10] = 2'd0;
            if ($urandom % 2 != 0) ra[7:6] = 2'd0;
            if ($urandom % 4 == 0) ra[11:7] = 5'd0;
            step($urandom % 4 != 0, $urandom % 8 == 0, ra, $urandom % 3 != 0);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
